// File: rtl/detector_event_reader.sv
`default_nettype none
// ============================================================================
// Module   : detector_event_reader
// Purpose  : Synchronises an asynchronous detector hit bus and opens a
//            coincidence window on the first masked hit. Hits are ORed over
//            the window, and the event is classified by how many detector
//            groups were hit. Accepted events go out as {timestamp, pattern}
//            records on an AXI4-Stream master. A programmable dead time
//            follows each decision.
// Ports    : aclk, aresetn (sync, active-low)
//            det_data        - asynchronous hit bus
//            cfg_window      - extra window cycles after the trigger
//            cfg_dead        - dead-time cycles after a decision (+1)
//            cfg_mask        - per-channel enable
//            cfg_min_groups  - groups required to accept an event
//            test_data       - per-group OR of the accumulated pattern
//            m_axis_*        - record stream {timestamp, pattern}
//            event_cntr      - accepted events emitted
//            drop_cntr       - accepted events dropped (output busy)
// Revision : 1.0 - initial release
// ============================================================================
module detector_event_reader #(
  parameter int DET_WIDTH   = 64,
  parameter int GROUP_WIDTH = 16,
  parameter int CNTR_WIDTH  = 8,
  parameter int TS_WIDTH    = 32,
  parameter int SYNC_FF     = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [DET_WIDTH-1:0]          det_data,
  input  logic [CNTR_WIDTH-1:0]         cfg_window,
  input  logic [CNTR_WIDTH-1:0]         cfg_dead,
  input  logic [DET_WIDTH-1:0]          cfg_mask,
  input  logic [7:0]                    cfg_min_groups,
  output logic [DET_WIDTH/GROUP_WIDTH-1:0] test_data,
  output logic [TS_WIDTH+DET_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [31:0]                   event_cntr,
  output logic [31:0]                   drop_cntr
);

  localparam int GROUPS = DET_WIDTH / GROUP_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    DEAD    = 2'd3
  } state_t;

  state_t                        r_state, w_state_n;
  logic [DET_WIDTH-1:0]          r_sync [SYNC_FF];
  logic [DET_WIDTH-1:0]          r_acc, w_acc_n;
  logic [CNTR_WIDTH-1:0]         r_cntr, w_cntr_n;
  logic [TS_WIDTH-1:0]           r_ts;
  logic [TS_WIDTH-1:0]           r_ts_lat, w_ts_lat_n;
  logic [TS_WIDTH+DET_WIDTH-1:0] r_tdata, w_tdata_n;
  logic                          r_tvalid, w_tvalid_n;
  logic [31:0]                   r_evt, w_evt_n;
  logic [31:0]                   r_drop, w_drop_n;
  logic [DET_WIDTH-1:0]          w_hit;
  logic [GROUPS-1:0]             w_grp_or;
  logic [8:0]                    w_ngroups;
  logic                          w_accept;
  logic                          w_slot_free;

  // Per-bit synchroniser; no coherence across the bus is implied.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < SYNC_FF; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= det_data;
      for (int i = 1; i < SYNC_FF; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_hit = r_sync[SYNC_FF-1] & cfg_mask;

  always_ff @(posedge aclk) begin
    if (!aresetn) r_ts <= '0;
    else          r_ts <= r_ts + TS_WIDTH'(1);
  end

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    assign w_grp_or[g] = |r_acc[g*GROUP_WIDTH +: GROUP_WIDTH];
  end

  always_comb begin
    w_ngroups = '0;
    for (int g = 0; g < GROUPS; g++) w_ngroups = w_ngroups + {8'd0, w_grp_or[g]};
  end

  assign w_accept    = (w_ngroups >= {1'b0, cfg_min_groups});
  // The output register can take a new record if empty or draining this cycle.
  assign w_slot_free = !r_tvalid || m_axis_tready;

  always_comb begin
    w_state_n  = r_state;
    w_acc_n    = r_acc;
    w_cntr_n   = r_cntr;
    w_ts_lat_n = r_ts_lat;
    w_tdata_n  = r_tdata;
    w_tvalid_n = r_tvalid && !m_axis_tready;
    w_evt_n    = r_evt;
    w_drop_n   = r_drop;
    case (r_state)
      IDLE: begin
        w_acc_n  = w_hit;
        w_cntr_n = '0;
        if (|w_hit) begin
          w_ts_lat_n = r_ts;
          w_state_n  = COLLECT;
        end
      end
      COLLECT: begin
        w_acc_n  = r_acc | w_hit;
        w_cntr_n = r_cntr + CNTR_WIDTH'(1);
        if (r_cntr >= cfg_window) w_state_n = DECIDE;
      end
      DECIDE: begin
        w_cntr_n  = '0;
        w_state_n = DEAD;
        if (w_accept) begin
          if (w_slot_free) begin
            // A reload in the handshake cycle keeps tvalid asserted.
            w_tdata_n  = {r_ts_lat, r_acc};
            w_tvalid_n = 1'b1;
            w_evt_n    = r_evt + 32'd1;
          end else begin
            w_drop_n = r_drop + 32'd1;
          end
        end
      end
      DEAD: begin
        w_cntr_n = r_cntr + CNTR_WIDTH'(1);
        if (r_cntr >= cfg_dead) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cntr   <= '0;
      r_ts_lat <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_evt    <= '0;
      r_drop   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_acc    <= w_acc_n;
      r_cntr   <= w_cntr_n;
      r_ts_lat <= w_ts_lat_n;
      r_tdata  <= w_tdata_n;
      r_tvalid <= w_tvalid_n;
      r_evt    <= w_evt_n;
      r_drop   <= w_drop_n;
    end
  end

  assign test_data     = w_grp_or;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign event_cntr    = r_evt;
  assign drop_cntr     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_detector_event_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_detector_event_reader
// Purpose  : Directed self-checking bench for detector_event_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_detector_event_reader;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] det_data;
  logic [7:0]  cfg_window;
  logic [7:0]  cfg_dead;
  logic [63:0] cfg_mask;
  logic [7:0]  cfg_min_groups;
  logic [3:0]  test_data;
  logic [95:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] event_cntr;
  logic [31:0] drop_cntr;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] tb_ts;
  logic [95:0] rec [$];

  detector_event_reader dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .det_data       (det_data),
    .cfg_window     (cfg_window),
    .cfg_dead       (cfg_dead),
    .cfg_mask       (cfg_mask),
    .cfg_min_groups (cfg_min_groups),
    .test_data      (test_data),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .event_cntr     (event_cntr),
    .drop_cntr      (drop_cntr)
  );

  always #5 aclk = ~aclk;

  // Reference cycle count since the last reset edge.
  always @(posedge aclk) tb_ts <= aresetn ? tb_ts + 32'd1 : 32'd0;

  // Record every handshake (inputs settle at negedge, sampled 2 ns later).
  always @(negedge aclk) begin
    #2;
    if (aresetn && m_axis_tvalid && m_axis_tready) rec.push_back(m_axis_tdata);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic pulse(input logic [63:0] v);
    det_data = v;
    tick(1);
    det_data = '0;
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (rec.size() < target && k < 60) begin
      tick(1);
      k++;
    end
    chk("hs_wait", 128'(rec.size()), 128'(target));
  endtask

  logic [31:0] t0;

  initial begin
    aresetn        = 1'b0;
    det_data       = '0;
    cfg_window     = 8'd3;
    cfg_dead       = 8'd2;
    cfg_mask       = '1;
    cfg_min_groups = 8'd1;
    m_axis_tready  = 1'b1;

    // Reset state
    tick(3);
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_tdata",  128'(m_axis_tdata),  128'(0));
    chk("rst_test",   128'(test_data),     128'(0));
    chk("rst_evt",    128'(event_cntr),    128'(0));
    chk("rst_drop",   128'(drop_cntr),     128'(0));
    aresetn = 1'b1;
    tick(2);

    // 1: single hit on bit 5, then a hit in the last dead cycle (ignored)
    //    followed by one in the first idle cycle (accepted).
    t0 = tb_ts;
    pulse(64'h20);
    tick(3);
    chk("t1_test_trig", 128'(test_data), 128'(0));
    tick(1);
    chk("t1_test_coll", 128'(test_data), 128'(4'b0001));
    tick(3);
    chk("t1_test_coll2", 128'(test_data), 128'(4'b0001));
    det_data = 64'h40;
    tick(1);
    det_data = 64'h80;
    tick(1);
    det_data = '0;
    wait_hs(2);
    chk("t1_rec0", 128'(rec[0]), 128'({t0 + 32'd4, 64'h20}));
    chk("t1_rec1", 128'(rec[1]), 128'({t0 + 32'd13, 64'h80}));
    chk("t1_evt",  128'(event_cntr), 128'(2));
    chk("t1_drop", 128'(drop_cntr),  128'(0));
    tick(10);

    // 2: two-group coincidence inside the window, then outside it.
    cfg_window     = 8'd4;
    cfg_min_groups = 8'd2;
    tick(1);
    t0 = tb_ts;
    pulse(64'h1);
    tick(1);
    pulse(64'h100_0000_0000);
    wait_hs(3);
    chk("t2_rec", 128'(rec[2]), 128'({t0 + 32'd4, 64'h0000_0100_0000_0001}));
    chk("t2_evt", 128'(event_cntr), 128'(3));
    tick(10);
    pulse(64'h1);
    tick(6);
    pulse(64'h100_0000_0000);
    tick(20);
    chk("t2_rej_n",    128'(rec.size()), 128'(3));
    chk("t2_rej_evt",  128'(event_cntr), 128'(3));
    chk("t2_rej_drop", 128'(drop_cntr),  128'(0));

    // 3: masked-off hits never trigger.
    cfg_mask       = 64'hFFFF_0000_0000_0000;
    cfg_min_groups = 8'd1;
    det_data       = 64'h0000_FFFF_FFFF_FFFF;
    tick(6);
    chk("t3_test", 128'(test_data), 128'(0));
    tick(4);
    det_data = '0;
    tick(8);
    chk("t3_test2", 128'(test_data),  128'(0));
    chk("t3_n",     128'(rec.size()), 128'(3));
    chk("t3_evt",   128'(event_cntr), 128'(3));
    cfg_mask = '1;
    tick(2);

    // 4: backpressure, second accepted event dropped.
    cfg_window    = 8'd0;
    cfg_dead      = 8'd0;
    m_axis_tready = 1'b0;
    t0 = tb_ts;
    pulse(64'h2);
    tick(7);
    chk("t4_tvalid", 128'(m_axis_tvalid), 128'(1));
    chk("t4_tdata",  128'(m_axis_tdata),  128'({t0 + 32'd4, 64'h2}));
    tick(2);
    pulse(64'h4);
    tick(7);
    chk("t4_tdata_hold", 128'(m_axis_tdata), 128'({t0 + 32'd4, 64'h2}));
    chk("t4_tvalid2",    128'(m_axis_tvalid), 128'(1));
    chk("t4_drop",       128'(drop_cntr),  128'(1));
    chk("t4_evt",        128'(event_cntr), 128'(4));
    m_axis_tready = 1'b1;
    tick(1);
    chk("t4_tvalid_lo", 128'(m_axis_tvalid), 128'(0));
    chk("t4_n",         128'(rec.size()),    128'(4));
    chk("t4_rec",       128'(rec[3]),        128'({t0 + 32'd4, 64'h2}));
    tick(4);

    // 5: handshake of the held record in the same cycle as a new accept.
    m_axis_tready = 1'b0;
    t0 = tb_ts;
    pulse(64'h8);
    tick(9);
    pulse(64'h10);
    tick(5);
    m_axis_tready = 1'b1;
    tick(1);
    chk("t5_tvalid", 128'(m_axis_tvalid), 128'(1));
    chk("t5_tdata",  128'(m_axis_tdata),  128'({t0 + 32'd14, 64'h10}));
    chk("t5_drop",   128'(drop_cntr),     128'(1));
    chk("t5_evt",    128'(event_cntr),    128'(6));
    chk("t5_recC",   128'(rec[4]),        128'({t0 + 32'd4, 64'h8}));
    tick(1);
    chk("t5_n",    128'(rec.size()),    128'(6));
    chk("t5_recD", 128'(rec[5]),        128'({t0 + 32'd14, 64'h10}));
    chk("t5_lo",   128'(m_axis_tvalid), 128'(0));
    tick(4);

    // 6: reset during a collect window while a record is pending.
    m_axis_tready = 1'b0;
    cfg_window    = 8'd10;
    pulse(64'h100);
    tick(19);
    pulse(64'h400);
    tick(6);
    chk("t6_pre_tvalid", 128'(m_axis_tvalid), 128'(1));
    chk("t6_pre_evt",    128'(event_cntr),    128'(7));
    aresetn = 1'b0;
    tick(1);
    chk("t6_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("t6_tdata",  128'(m_axis_tdata),  128'(0));
    chk("t6_test",   128'(test_data),     128'(0));
    chk("t6_evt",    128'(event_cntr),    128'(0));
    chk("t6_drop",   128'(drop_cntr),     128'(0));
    aresetn = 1'b1;
    tick(2);
    m_axis_tready = 1'b1;
    pulse(64'h200);
    wait_hs(7);
    chk("t6_rec",     128'(rec[6]),     128'({32'd6, 64'h200}));
    chk("t6_evt_new", 128'(event_cntr), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
